// File: rtl/cfg_reg_write_arbiter.sv
// cfg_reg_write_arbiter
// Shares one write path into a bank of 32-bit configuration registers between
// NREQ requesters. One write is sequenced at a time through IDLE -> GRANT ->
// WRITE -> DONE, with round-robin arbitration and a per-requester ack/err pulse.
// Optional feature: define CFG_WRITE_LOCK_EN to add a 'lock' input and a
// LOCK_MASK parameter that rejects writes to masked registers while locked.

module cfg_reg_write_arbiter #(
  parameter int NREQ = 2,
  parameter int NREG = 16,
  parameter int AW   = 5
`ifdef CFG_WRITE_LOCK_EN
  ,
  parameter logic [NREG-1:0] LOCK_MASK = '1
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_enable,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*32-1:0] req_data,
`ifdef CFG_WRITE_LOCK_EN
  input  logic               lock,
`endif
  output logic [NREQ-1:0]    req_ack,
  output logic [NREQ-1:0]    req_err,
  output logic [NREG-1:0]    reg_sel,
  output logic               reg_wr_stb,
  output logic [31:0]        reg_wdata,
  output logic               busy,
  output logic [1:0]         grant_id,
  output logic [15:0]        write_count
);

  typedef enum logic [1:0] {IDLE, GRANT, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        rr_ptr;
  logic [AW-1:0]     addr_q;

  logic              pick_found;
  logic [1:0]        pick_id;
  logic [AW-1:0]     pick_addr;
  logic [31:0]       pick_data;
  logic              reject;
  logic [NREG-1:0]   sel_d;
  logic [NREQ-1:0]   gid_hot;
  logic [1:0]        next_ptr;
  int                idx;

  assign busy = (state_q != IDLE);

  // Round-robin pick, address/lock check and next-state decision
  always_comb begin
    state_d    = state_q;
    pick_found = 1'b0;
    pick_id    = '0;
    pick_addr  = '0;
    pick_data  = '0;
    idx        = 0;
    sel_d      = '0;
    gid_hot    = '0;
    reject     = (int'(addr_q) >= NREG);

    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!pick_found && req_valid[idx]) begin
        pick_found = 1'b1;
        pick_id    = 2'(idx);
        pick_addr  = req_addr[idx*AW +: AW];
        pick_data  = req_data[idx*32 +: 32];
      end
    end

    for (int i = 0; i < NREG; i++) begin
      sel_d[i] = (addr_q == AW'(i));
`ifdef CFG_WRITE_LOCK_EN
      if (lock && LOCK_MASK[i] && (addr_q == AW'(i))) reject = 1'b1;
`endif
    end

    for (int i = 0; i < NREQ; i++) begin
      gid_hot[i] = (grant_id == 2'(i));
    end

    next_ptr = (grant_id == 2'(NREQ-1)) ? 2'd0 : grant_id + 2'd1;

    case (state_q)
      IDLE:    if (cfg_enable && pick_found) state_d = GRANT;
      GRANT:   state_d = reject ? DONE : WRITE;
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Latched request, bank-side strobes, handshake pulses and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_id    <= '0;
      addr_q      <= '0;
      reg_wdata   <= '0;
      reg_sel     <= '0;
      reg_wr_stb  <= 1'b0;
      req_ack     <= '0;
      req_err     <= '0;
      write_count <= '0;
      rr_ptr      <= '0;
    end else begin
      req_ack <= '0;
      req_err <= '0;
      case (state_q)
        IDLE: begin
          if (state_d == GRANT) begin
            grant_id  <= pick_id;
            addr_q    <= pick_addr;
            reg_wdata <= pick_data;
          end
        end
        GRANT: begin
          if (reject) begin
            req_err <= gid_hot;
            rr_ptr  <= next_ptr;
          end else begin
            reg_sel    <= sel_d;
            reg_wr_stb <= 1'b1;
          end
        end
        WRITE: begin
          reg_sel     <= '0;
          reg_wr_stb  <= 1'b0;
          req_ack     <= gid_hot;
          write_count <= write_count + 16'd1;
          rr_ptr      <= next_ptr;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_reg_write_arbiter.sv
// tb_cfg_reg_write_arbiter
// Directed bench for cfg_reg_write_arbiter with a transaction-level model that
// predicts every output on every cycle. Honours CFG_WRITE_LOCK_EN when defined.

module tb_cfg_reg_write_arbiter;

  localparam int NREQ = 2;
  localparam int NREG = 16;
  localparam int AW   = 5;
`ifdef CFG_WRITE_LOCK_EN
  localparam logic [NREG-1:0] LOCK_MASK_TB = 16'h0001;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               cfg_enable = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*32-1:0] req_data = '0;
`ifdef CFG_WRITE_LOCK_EN
  logic               lock = 1'b0;
`endif
  logic [NREQ-1:0]    req_ack;
  logic [NREQ-1:0]    req_err;
  logic [NREG-1:0]    reg_sel;
  logic               reg_wr_stb;
  logic [31:0]        reg_wdata;
  logic               busy;
  logic [1:0]         grant_id;
  logic [15:0]        write_count;

  int checks = 0;
  int errors = 0;

  cfg_reg_write_arbiter #(
    .NREQ(NREQ), .NREG(NREG), .AW(AW)
`ifdef CFG_WRITE_LOCK_EN
    , .LOCK_MASK(LOCK_MASK_TB)
`endif
  ) dut (
    .clk(clk), .reset(reset), .cfg_enable(cfg_enable),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
`ifdef CFG_WRITE_LOCK_EN
    .lock(lock),
`endif
    .req_ack(req_ack), .req_err(req_err), .reg_sel(reg_sel),
    .reg_wr_stb(reg_wr_stb), .reg_wdata(reg_wdata), .busy(busy),
    .grant_id(grant_id), .write_count(write_count)
  );

  always #5 clk = ~clk;

  // Shared comparison: counts every check and reports misses
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a transaction is described by its phase (edges since it
  // was accepted), the winner, its address/data and whether it is accepted.
  int          m_active = 0;
  int          m_ph = 0;
  bit          m_ok = 0;
  int          m_gid = 0;
  int          m_ptr = 0;
  int          m_addr = 0;
  logic [31:0] m_wdata = '0;
  logic [15:0] m_count = '0;

  function automatic int rrPick(input int ptr, input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic bit writeAllowed(input int addr);
    if (addr >= NREG) return 0;
`ifdef CFG_WRITE_LOCK_EN
    if (lock && LOCK_MASK_TB[addr]) return 0;
`endif
    return 1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active = 0; m_ph = 0; m_ok = 0; m_gid = 0; m_ptr = 0;
      m_addr = 0; m_wdata = '0; m_count = '0;
    end else if (m_active != 0) begin
      m_ph++;
      if (m_ph == 2) m_ok = writeAllowed(m_addr);
      if (m_ph == (m_ok ? 3 : 2)) begin
        if (m_ok) m_count = m_count + 16'd1;
        m_ptr = (m_gid + 1) % NREQ;
      end
      if (m_ph == (m_ok ? 4 : 3)) m_active = 0;
    end else if (cfg_enable && (req_valid != '0)) begin
      m_gid    = rrPick(m_ptr, req_valid);
      m_addr   = int'(req_addr[m_gid*AW +: AW]);
      m_wdata  = req_data[m_gid*32 +: 32];
      m_ok     = 0;
      m_active = 1;
      m_ph     = 1;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    logic [31:0] e_sel, e_ack, e_err;
    logic        e_stb;
    e_stb = (m_active != 0) && m_ok && (m_ph == 2);
    e_sel = e_stb ? (32'd1 << m_addr) : 32'd0;
    e_ack = ((m_active != 0) && m_ok && (m_ph == 3)) ? (32'd1 << m_gid) : 32'd0;
    e_err = ((m_active != 0) && !m_ok && (m_ph == 2)) ? (32'd1 << m_gid) : 32'd0;
    checkOutput("busy", 32'(busy), 32'(m_active != 0));
    checkOutput("grant_id", 32'(grant_id), 32'(m_gid));
    checkOutput("reg_wdata", reg_wdata, m_wdata);
    checkOutput("reg_sel", 32'(reg_sel), e_sel);
    checkOutput("reg_wr_stb", 32'(reg_wr_stb), 32'(e_stb));
    checkOutput("req_ack", 32'(req_ack), e_ack);
    checkOutput("req_err", 32'(req_err), e_err);
    checkOutput("write_count", 32'(write_count), 32'(m_count));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic en, input logic [NREQ-1:0] v,
                               input logic [AW-1:0] a0, input logic [31:0] d0,
                               input logic [AW-1:0] a1, input logic [31:0] d1);
    cfg_enable = en;
    req_valid  = v;
    req_addr   = {a1, a0};
    req_data   = {d1, d0};
  endtask

  // Advance until a handshake pulse appears (bounded), then check it
  task automatic waitResp(input string name, input logic [NREQ-1:0] exp_ack,
                          input logic [NREQ-1:0] exp_err, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (req_ack == '0 && req_err == '0 && n < 12);
    checkOutput({name, "_ack"}, 32'(req_ack), 32'(exp_ack));
    checkOutput({name, "_err"}, 32'(req_err), 32'(exp_err));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;

    // Reset state
    repeat (3) tick();
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_count", 32'(write_count), 32'd0);
    reset = 1'b0;
    tick();

    // Single write: requester 0, addr 3
    applyStimulus(1'b1, 2'b01, 5'd3, 32'hDEADBEEF, 5'd0, 32'h0);
    tick();
    checkOutput("single_busy", 32'(busy), 32'd1);
    tick();
    checkOutput("single_sel", 32'(reg_sel), 32'h0008);
    checkOutput("single_stb", 32'(reg_wr_stb), 32'd1);
    checkOutput("single_wdata", reg_wdata, 32'hDEADBEEF);
    tick();
    checkOutput("single_ack", 32'(req_ack), 32'd1);
    checkOutput("single_count", 32'(write_count), 32'd1);
    req_valid = 2'b00;
    tick();
    checkOutput("single_idle", 32'(busy), 32'd0);

    // Bad address from requester 1
    applyStimulus(1'b1, 2'b10, 5'd0, 32'h0, 5'd20, 32'h12345678);
    waitResp("bad", 2'b00, 2'b10, n);
    checkOutput("bad_latency", 32'(n), 32'd2);
    checkOutput("bad_count", 32'(write_count), 32'd1);
    req_valid = 2'b00;
    tick();

    // Contention: 0 then 1 then 0 again (re-request of addr 5)
    applyStimulus(1'b1, 2'b11, 5'd1, 32'h11111111, 5'd2, 32'h22222222);
    waitResp("cont0", 2'b01, 2'b00, n);
    checkOutput("cont0_latency", 32'(n), 32'd3);
    checkOutput("cont0_wdata", reg_wdata, 32'h11111111);
    req_addr[AW-1:0] = 5'd5;
    req_data[31:0]   = 32'h55555555;
    waitResp("cont1", 2'b10, 2'b00, n);
    checkOutput("cont1_spacing", 32'(n), 32'd4);
    checkOutput("cont1_wdata", reg_wdata, 32'h22222222);
    req_valid[1] = 1'b0;
    waitResp("cont2", 2'b01, 2'b00, n);
    checkOutput("cont2_spacing", 32'(n), 32'd4);
    checkOutput("cont2_wdata", reg_wdata, 32'h55555555);
    checkOutput("cont_count", 32'(write_count), 32'd4);
    req_valid = 2'b00;
    tick();

    // Gating: held request with cfg_enable low, then enable; drop enable after grant
    applyStimulus(1'b0, 2'b01, 5'd7, 32'hCAFEF00D, 5'd0, 32'h0);
    repeat (10) tick();
    checkOutput("gate_busy", 32'(busy), 32'd0);
    cfg_enable = 1'b1;
    tick();
    checkOutput("gate_grant", 32'(busy), 32'd1);
    cfg_enable = 1'b0;
    waitResp("gate", 2'b01, 2'b00, n);
    checkOutput("gate_latency", 32'(n + 1), 32'd3);
    checkOutput("gate_count", 32'(write_count), 32'd5);
    req_valid = 2'b00;
    cfg_enable = 1'b1;
    tick();

    // Reset in the middle of a write
    applyStimulus(1'b1, 2'b01, 5'd9, 32'h99999999, 5'd0, 32'h0);
    tick();
    tick();
    checkOutput("rst_pre_stb", 32'(reg_wr_stb), 32'd1);
    #1 reset = 1'b1;
    #1;
    checkOutput("rst_sel", 32'(reg_sel), 32'd0);
    checkOutput("rst_stb", 32'(reg_wr_stb), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_wdata", reg_wdata, 32'd0);
    checkOutput("rst_count", 32'(write_count), 32'd0);
    req_valid = 2'b00;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    applyStimulus(1'b1, 2'b01, 5'd0, 32'h5A5A5A5A, 5'd0, 32'h0);
    waitResp("post_rst", 2'b01, 2'b00, n);
    checkOutput("post_rst_latency", 32'(n), 32'd3);
    checkOutput("post_rst_wdata", reg_wdata, 32'h5A5A5A5A);
    checkOutput("post_rst_count", 32'(write_count), 32'd1);
    req_valid = 2'b00;
    tick();

`ifdef CFG_WRITE_LOCK_EN
    // Lock: addr 0 is masked, addr 1 is not
    lock = 1'b1;
    applyStimulus(1'b1, 2'b01, 5'd0, 32'hAAAA0000, 5'd0, 32'h0);
    waitResp("lock0", 2'b00, 2'b01, n);
    req_valid = 2'b00;
    tick();
    applyStimulus(1'b1, 2'b01, 5'd1, 32'hAAAA0001, 5'd0, 32'h0);
    tick();
    tick();
    checkOutput("lock1_stb", 32'(reg_wr_stb), 32'd1);
    checkOutput("lock1_sel", 32'(reg_sel), 32'h0002);
    waitResp("lock1", 2'b01, 2'b00, n);
    req_valid = 2'b00;
    lock = 1'b0;
    tick();
`endif

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cfg_reg_write_arbiter.md
Name: cfg_reg_write_arbiter

Overview:
Shares one write path into a bank of 32-bit configuration registers between several requesters, e.g. a host command decoder and a power-up default loader. Each bank register has two clock enables and an async reset. This block drives one enable as a one-hot register select and the other as a common write strobe. It sequences one write at a time, arbitrates round-robin, and returns a per-requester ack/error handshake.

Parameters:
NREQ, 2, number of requesters (2..4)
NREG, 16, number of 32-bit registers in the bank (2..32)
AW, 5, address width per requester; must satisfy 2^AW >= NREG

Ports:
clk  in  1  system clock
reset  in  1  reset; asynchronous, active-high
cfg_enable  in  1  global write enable; low = no new grants
req_valid  in  NREQ  write request per requester; level, held until ack/err
req_addr  in  NREQ*AW  register address; requester i uses bits [i*AW +: AW]
req_data  in  NREQ*32  write data; requester i uses bits [i*32 +: 32]
req_ack  out  NREQ  one-cycle pulse: write completed
req_err  out  NREQ  one-cycle pulse: request rejected (bad address or locked)
reg_sel  out  NREG  one-hot register select, drives clock enable 1 of each register
reg_wr_stb  out  1  common write strobe, drives clock enable 2 of all registers
reg_wdata  out  32  registered write data to the bank
busy  out  1  high in any state other than IDLE
grant_id  out  2  index of the current or last granted requester
write_count  out  16  completed-write counter; wraps 0xFFFF->0

Behaviour:
- Reset values:
  - State = IDLE.
  - reg_sel, reg_wr_stb, reg_wdata, req_ack, req_err, busy, grant_id, write_count all 0.
  - Round-robin pointer = 0, so requester 0 has top priority.
- FSM states: IDLE, GRANT, WRITE, DONE.
- IDLE:
  - If cfg_enable=1 and any req_valid=1, pick the first valid requester at or after the pointer, searching upward with wrap.
  - Register grant_id, the requester's address and its data into reg_wdata.
  - Go to GRANT.
- GRANT:
  - Check the latched address. If address >= NREG (or the lock is active, see Optional Feature), go to DONE with error.
  - Otherwise set reg_sel to one-hot of the address and go to WRITE.
- WRITE:
  - reg_wr_stb=1 for exactly one cycle while reg_sel is valid and reg_wdata is stable; the bank loads on this edge.
  - Go to DONE.
- DONE:
  - reg_sel=0, reg_wr_stb=0.
  - Pulse req_ack[grant_id] (success) or req_err[grant_id] (error) for one cycle.
  - On success, increment write_count.
  - Pointer = grant_id+1, modulo NREQ.
  - Return to IDLE.
- Latency:
  - From req_valid sampled in IDLE to ack: 4 cycles for a valid write (IDLE, GRANT, WRITE, DONE).
  - Error path: 3 cycles (IDLE, GRANT, DONE).
  - Minimum spacing between back-to-back writes: 4 cycles.
- reg_sel and reg_wr_stb are never both nonzero outside WRITE. At most one reg_sel bit is high at any time.
- Handshake:
  - Requester inputs are sampled only in IDLE; changes after grant are ignored.
  - A requester must drop req_valid in the cycle after ack/err, otherwise it is treated as a new request.
- If req_valid of the granted requester drops mid-transaction, the transaction still completes and ack is still pulsed.
- cfg_enable falling after grant does not abort the transaction; it only blocks the next grant.
- Simultaneous requests are served round-robin. With all requesters permanently valid, grants cycle 0,1,..,NREQ-1,0.
- Async reset mid-transaction:
  - All outputs clear immediately and no ack/err is issued.
  - A write in progress is lost; bank registers reload their defaults under the same reset.

Optional Feature:
- Macro: CFG_WRITE_LOCK_EN.
- When defined:
  - Adds input lock (1 bit) and parameter LOCK_MASK (NREG bits, default all ones).
  - In GRANT, if lock=1 and LOCK_MASK[addr]=1, the request ends with req_err and no strobe.
  - Unmasked registers remain writable while locked.
- When undefined: no lock port; only the address range check produces errors.

Test Plan:
- Single write:
  - Stimulus: requester 0 writes addr 3, data 0xDEADBEEF.
  - Response: reg_sel=0x0008 and reg_wr_stb=1 for one cycle, 2 cycles after the request is sampled. req_ack[0] pulses in the next cycle. write_count=1.
- Contention:
  - Stimulus: req 0 (addr 1, 0x11111111) and req 1 (addr 2, 0x22222222) assert in the same cycle; after req 0 is acked it re-requests addr 5.
  - Response: service order is req 0, req 1, req 0. Each ack is 4 cycles apart.
- Bad address:
  - Stimulus: NREG=16, requester 1 writes addr 20.
  - Response: no reg_wr_stb. req_err[1] pulses 3 cycles after sampling. write_count unchanged.
- Gating:
  - Stimulus: cfg_enable=0 with req_valid[0]=1 for 10 cycles, then cfg_enable=1.
  - Response: busy stays 0 while disabled. The write occurs and ack arrives 4 cycles after enable.
- Reset mid-write:
  - Stimulus: assert reset while in WRITE.
  - Response: all outputs are 0 in the same cycle and no ack is issued. After release, a fresh write to addr 0 of 0x5A5A5A5A completes normally.
- Lock (with CFG_WRITE_LOCK_EN):
  - Stimulus: LOCK_MASK=0x0001, lock=1; write addr 0, then write addr 1.
  - Response: addr 0 returns req_err. Addr 1 returns req_ack with the strobe asserted.
